slim_ctrl: RTL



---
 rtl/slim_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/slim_ctrl.sv
// rtl/slim_ctrl.sv - slime enemy behaviour controller: patrol, freeze, death and respawn
module slim_ctrl #(
    parameter logic [9:0] X_MIN          = 10'd100,
    parameter logic [9:0] X_MAX          = 10'd500,
    parameter logic [8:0] Y_POS          = 9'd300,
    parameter logic [9:0] SPEED          = 10'd2,
    parameter logic [7:0] FREEZE_FRAMES  = 8'd120,
    parameter logic [7:0] DIE_FRAMES     = 8'd16,
    parameter logic [7:0] RESPAWN_FRAMES = 8'd180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       ice_hit,
    input  logic       broken,
    output logic [9:0] x_slim,
    output logic [8:0] y_slim,
    output logic       isfrozen,
    output logic       visible,
    output logic       dir,
    output logic [1:0] anim_frame,
    output logic       score_pulse
);

    typedef enum logic [1:0] {
        PATROL = 2'd0,
        FROZEN = 2'd1,
        DYING  = 2'd2,
        DEAD   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic       dir_q, dir_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] walk_q, walk_d;
    logic       isfrozen_q, isfrozen_d;
    logic       visible_q, visible_d;
    logic [1:0] anim_q, anim_d;
    logic       score_q, score_d;

    logic [9:0] x_fwd;
    logic [9:0] x_back;
    logic [9:0] left_limit;
    logic       cnt_last;

    // Bounds are tested before stepping so the 10-bit position never wraps.
    assign x_fwd      = x_q + SPEED;
    assign x_back     = x_q - SPEED;
    assign left_limit = X_MIN + SPEED;
    assign cnt_last   = (cnt_q == 8'd1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        walk_d  = walk_q;
        score_d = 1'b0;

        case (state_q)
            PATROL: begin
                if (broken) begin
                    state_d = DYING;
                    cnt_d   = DIE_FRAMES;
                    score_d = 1'b1;
                end else if (ice_hit) begin
                    state_d = FROZEN;
                    cnt_d   = FREEZE_FRAMES;
                end else if (frame_tick) begin
                    walk_d = walk_q + 4'd1;
                    if (dir_q) begin
                        if (x_fwd >= X_MAX) begin
                            x_d   = X_MAX;
                            dir_d = 1'b0;
                        end else begin
                            x_d = x_fwd;
                        end
                    end else begin
                        if (x_q <= left_limit) begin
                            x_d   = X_MIN;
                            dir_d = 1'b1;
                        end else begin
                            x_d = x_back;
                        end
                    end
                end
            end
            FROZEN: begin
                // A fresh hit restarts the freeze and swallows a coincident tick.
                if (ice_hit) begin
                    cnt_d = FREEZE_FRAMES;
                end else if (frame_tick) begin
                    if (cnt_last) begin
                        state_d = PATROL;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (cnt_last) begin
                        state_d = DEAD;
                        cnt_d   = RESPAWN_FRAMES;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            DEAD: begin
                if (frame_tick) begin
                    if (cnt_last) begin
                        state_d = PATROL;
                        x_d     = X_MIN;
                        dir_d   = 1'b1;
                        walk_d  = 4'd0;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = PATROL;
            end
        endcase

        // Outputs follow the next state so they land on the same edge as the transition.
        isfrozen_d = (state_d == FROZEN);
        visible_d  = (state_d != DEAD);
        case (state_d)
            PATROL:  anim_d = {1'b0, walk_d[3]};
            FROZEN:  anim_d = 2'd2;
            DYING:   anim_d = 2'd3;
            default: anim_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PATROL;
            x_q        <= X_MIN;
            dir_q      <= 1'b1;
            cnt_q      <= 8'd0;
            walk_q     <= 4'd0;
            isfrozen_q <= 1'b0;
            visible_q  <= 1'b1;
            anim_q     <= 2'd0;
            score_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            walk_q     <= walk_d;
            isfrozen_q <= isfrozen_d;
            visible_q  <= visible_d;
            anim_q     <= anim_d;
            score_q    <= score_d;
        end
    end

    assign x_slim      = x_q;
    assign y_slim      = Y_POS;
    assign dir         = dir_q;
    assign isfrozen    = isfrozen_q;
    assign visible     = visible_q;
    assign anim_frame  = anim_q;
    assign score_pulse = score_q;

endmodule
